// File: rtl/latch_ctrl_pkg.sv
// rtl/latch_ctrl_pkg.sv - shared state encoding and pulse-length bounds for the latch write controller
package latch_ctrl_pkg;

   // Write sequence states; one operation walks IDLE->SETUP->PULSE->HOLD->DONE->IDLE.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } latch_state_t;

   // Legal range for the number of cycles the latch gate is held open.
   localparam int PULSE_CYC_MIN = 1;
   localparam int PULSE_CYC_MAX = 15;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with one-hot grant and enable
module rr_arbiter2 (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       req0_in,
   input  logic       req1_in,
   input  logic       en_in,
   output logic [1:0] grant_out
);

   // ptr = 0 favours requester 0 on a tie, ptr = 1 favours requester 1.
   logic ptr;

   // Grant decode: a lone request wins outright, a tie is broken by the pointer.
   always_comb begin
      grant_out = 2'b00;
      if (en_in) begin
         if (req0_in && req1_in) begin
            grant_out = ptr ? 2'b10 : 2'b01;
         end else if (req0_in) begin
            grant_out = 2'b01;
         end else if (req1_in) begin
            grant_out = 2'b10;
         end
      end
   end

   // Pointer update: after any grant the other requester gets priority.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ptr <= 1'b0;
      end else if (|grant_out) begin
         ptr <= grant_out[0];
      end
   end

endmodule

// File: rtl/latch_wr_arbiter.sv
// rtl/latch_wr_arbiter.sv - arbitrates two writers onto a gated D latch bank with registered gate pulses
module latch_wr_arbiter
   import latch_ctrl_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NUM_LATCH = 4,
   parameter int PULSE_CYC = 2
) (
   input  logic                         clk_in,
   input  logic                         rst_n_in,
   input  logic                         req0_in,
   input  logic                         req1_in,
   input  logic [$clog2(NUM_LATCH)-1:0] addr0_in,
   input  logic [$clog2(NUM_LATCH)-1:0] addr1_in,
   input  logic [DATA_W-1:0]            data0_in,
   input  logic [DATA_W-1:0]            data1_in,
   output logic                         ack0_out,
   output logic                         ack1_out,
   output logic [NUM_LATCH-1:0]         latch_c_out,
   output logic [DATA_W-1:0]            latch_d_out,
   output logic                         busy_out
);

   localparam int ADDR_W    = $clog2(NUM_LATCH);
   // Out-of-range pulse lengths are clamped into the legal window.
   localparam int PULSE_LEN = (PULSE_CYC < PULSE_CYC_MIN) ? PULSE_CYC_MIN :
                              (PULSE_CYC > PULSE_CYC_MAX) ? PULSE_CYC_MAX : PULSE_CYC;
   localparam int CNT_W     = $clog2(PULSE_LEN + 1);

   latch_state_t        state;
   logic [1:0]          grant;
   logic [CNT_W-1:0]    pulse_cnt;
   logic [ADDR_W-1:0]   cap_addr;
   logic                cap_sel;
   logic [NUM_LATCH-1:0] gate_sel;

   rr_arbiter2 u_arb (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .req0_in   (req0_in),
      .req1_in   (req1_in),
      .en_in     (state == ST_IDLE),
      .grant_out (grant)
   );

   // Gate decode from the captured index; an index past the bank selects nothing.
   always_comb begin
      gate_sel = '0;
      for (int i = 0; i < NUM_LATCH; i++) begin
         gate_sel[i] = (cap_addr == ADDR_W'(i));
      end
   end

   // Write sequencer: every output is a flop so the latch gates cannot glitch.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state       <= ST_IDLE;
         pulse_cnt   <= '0;
         cap_addr    <= '0;
         cap_sel     <= 1'b0;
         latch_c_out <= '0;
         latch_d_out <= '0;
         ack0_out    <= 1'b0;
         ack1_out    <= 1'b0;
         busy_out    <= 1'b0;
      end else begin
         ack0_out <= 1'b0;
         ack1_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|grant) begin
                  cap_sel     <= grant[1];
                  cap_addr    <= grant[1] ? addr1_in : addr0_in;
                  latch_d_out <= grant[1] ? data1_in : data0_in;
                  busy_out    <= 1'b1;
                  state       <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               latch_c_out <= gate_sel;
               pulse_cnt   <= CNT_W'(PULSE_LEN - 1);
               state       <= ST_PULSE;
            end
            ST_PULSE: begin
               if (pulse_cnt == '0) begin
                  latch_c_out <= '0;
                  state       <= ST_HOLD;
               end else begin
                  pulse_cnt <= pulse_cnt - CNT_W'(1);
               end
            end
            ST_HOLD: begin
               ack0_out <= ~cap_sel;
               ack1_out <= cap_sel;
               state    <= ST_DONE;
            end
            ST_DONE: begin
               busy_out <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               latch_c_out <= '0;
               busy_out    <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// tb/tb_latch_wr_arbiter.sv - self-checking bench for latch_wr_arbiter
module tb_latch_wr_arbiter;

   // Five latch words so that index 5 and 7 are representable yet out of range.
   localparam int DW = 8;
   localparam int NL = 5;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] data0 = '0, data1 = '0;
   logic          ack0, ack1, busy;
   logic [NL-1:0] latch_c;
   logic [DW-1:0] latch_d;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic          who;
      logic [DW-1:0] data;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      int            sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [NL-1:0] exp_c;
      bit            mutate;
   } vec_t;

   latch_wr_arbiter #(.DATA_W(DW), .NUM_LATCH(NL), .PULSE_CYC(2)) u_dut (
      .clk_in      (clk),
      .rst_n_in    (rst_n),
      .req0_in     (req0),
      .req1_in     (req1),
      .addr0_in    (addr0),
      .addr1_in    (addr1),
      .data0_in    (data0),
      .data1_in    (data1),
      .ack0_out    (ack0),
      .ack1_out    (ack1),
      .latch_c_out (latch_c),
      .latch_d_out (latch_d),
      .busy_out    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [15:0] outs();
      return {busy, ack1, ack0, latch_c, latch_d};
   endfunction

   // Scoreboard: every ack must match the oldest outstanding write.
   always @(negedge clk) begin
      if (ack0 || ack1) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_ack: got ack1/ack0=%b%b expected none", ack1, ack0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            if ({ack1, ack0, latch_d} !== {e.who, ~e.who, e.data}) begin
               n_fail++;
               $display("FAIL sb_ack: got ack=%b%b d=%h expected ack=%b%b d=%h",
                        ack1, ack0, latch_d, e.who, ~e.who, e.data);
            end
         end
      end
   end

   // One full write, called at a falling edge with the DUT idle; checks cycles 1..6.
   task automatic do_op(input vec_t v, input string name);
      logic [15:0] exp;
      if (v.sel == 0) begin req0 = 1'b1; addr0 = v.addr; data0 = v.data; end
      else            begin req1 = 1'b1; addr1 = v.addr; data1 = v.data; end
      sb_q.push_back('{who: (v.sel != 0), data: v.data});
      @(posedge clk);
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         exp = {(cyc <= 5), (cyc == 5 && v.sel == 1), (cyc == 5 && v.sel == 0),
                ((cyc == 2 || cyc == 3) ? v.exp_c : {NL{1'b0}}), v.data};
         check($sformatf("%s_c%0d", name, cyc), outs(), exp);
         if (v.mutate && cyc == 2) begin
            data0 = 8'h3C; data1 = 8'h3C; addr0 = '0; addr1 = '0;
            req0 = 1'b0; req1 = 1'b0;
         end
         if (cyc == 5) begin req0 = 1'b0; req1 = 1'b0; end
      end
   endtask

   initial begin
      vec_t vecs[7];
      logic [1:0] exp_ack;

      vecs[0] = '{sel: 0, addr: 3'd2, data: 8'hA5, exp_c: 5'b00100, mutate: 1'b0};
      vecs[1] = '{sel: 1, addr: 3'd0, data: 8'hC3, exp_c: 5'b00001, mutate: 1'b0};
      vecs[2] = '{sel: 0, addr: 3'd4, data: 8'h0F, exp_c: 5'b10000, mutate: 1'b0};
      vecs[3] = '{sel: 1, addr: 3'd5, data: 8'hE1, exp_c: 5'b00000, mutate: 1'b0};
      vecs[4] = '{sel: 1, addr: 3'd7, data: 8'h99, exp_c: 5'b00000, mutate: 1'b0};
      vecs[5] = '{sel: 0, addr: 3'd3, data: 8'h5A, exp_c: 5'b01000, mutate: 1'b0};
      vecs[6] = '{sel: 0, addr: 3'd2, data: 8'hA5, exp_c: 5'b00100, mutate: 1'b1};

      // Reset state, including with requests pending while held in reset.
      @(negedge clk);
      check("reset_idle", outs(), 16'h0000);
      req0 = 1'b1; req1 = 1'b1; data0 = 8'hFF; addr0 = 3'd1;
      @(negedge clk);
      check("reset_held", outs(), 16'h0000);

      // Both requesters held high out of reset: grants alternate 0,1,0,1.
      data0 = 8'h11; addr0 = 3'd1; data1 = 8'h22; addr1 = 3'd3;
      sb_q.push_back('{who: 1'b0, data: 8'h11});
      sb_q.push_back('{who: 1'b1, data: 8'h22});
      sb_q.push_back('{who: 1'b0, data: 8'h11});
      sb_q.push_back('{who: 1'b1, data: 8'h22});
      rst_n = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 23; cyc++) begin
         @(negedge clk);
         exp_ack = (cyc % 6 == 5) ? (((cyc / 6) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
         check($sformatf("rr_c%0d", cyc), {13'd0, busy, ack1, ack0}, {13'd0, (cyc % 6 != 0), exp_ack});
         check($sformatf("rr_onehot_c%0d", cyc), {15'd0, ($countones(latch_c) <= 1)}, 16'd1);
         if (cyc == 23) begin req0 = 1'b0; req1 = 1'b0; end
      end
      @(negedge clk);
      check("rr_idle", {15'd0, busy}, 16'd0);

      // Single-requester table, incl. out-of-range index and mid-op input changes.
      for (int i = 0; i < 7; i++) begin
         do_op(vecs[i], $sformatf("vec%0d", i));
      end
      check("d_retained", {8'd0, latch_d}, 16'h00A5);

      // Reset during the second PULSE cycle drops the gate immediately, no ack.
      req0 = 1'b1; addr0 = 3'd1; data0 = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      check("rstp_pulse1", {11'd0, latch_c}, 16'h0002);
      @(negedge clk);
      check("rstp_pulse2", {11'd0, latch_c}, 16'h0002);
      #1 rst_n = 1'b0; req0 = 1'b0;
      #1 check("rstp_async", outs(), 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         check($sformatf("rstp_quiet_c%0d", cyc), {13'd0, busy, ack1, ack0}, 16'd0);
      end

      // First edge after reset arbitrates normally.
      do_op('{sel: 1, addr: 3'd4, data: 8'h77, exp_c: 5'b10000, mutate: 1'b0}, "post_rst");

      check("sb_drained", 16'(sb_q.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
